// File: rtl/shared_fifo_ctrl.sv
// shared_fifo_ctrl: round-robin push arbiter and pointer controller for one shared FIFO array
module shared_fifo_ctrl #(
  parameter int NUM_REQ = 4,
  parameter int DEPTH   = 8,
  parameter int ADDR_W  = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic [NUM_REQ-1:0] req,
  input  logic               pop_req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               push,
  output logic               pop,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [ADDR_W-1:0]  rd_addr,
  output logic [ADDR_W:0]    count,
  output logic               full,
  output logic               empty
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   cnt;
  logic [IDX_W-1:0]  last_gnt, nxt_idx, k;
  logic              found;
  // first requesting producer after the last grantee, wrapping modulo NUM_REQ
  always_comb begin
    nxt_idx = '0;
    k = '0;
    found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      k = IDX_W'((int'(last_gnt) + i) % NUM_REQ);
      if (!found && req[k]) begin
        found = 1'b1;
        nxt_idx = k;
      end
    end
  end
  assign full    = cnt == (ADDR_W+1)'(DEPTH);
  assign empty   = cnt == '0;
  assign push    = reset & enable & found & !full;
  assign pop     = reset & enable & pop_req & !empty;
  assign gnt     = push ? NUM_REQ'(1) << nxt_idx : '0;
  assign wr_addr = wr_ptr;
  assign rd_addr = rd_ptr;
  assign count   = cnt;
  // pointers, occupancy and arbitration history advance only on issued strobes
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      last_gnt <= IDX_W'(NUM_REQ - 1);
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + 1'b1;
        last_gnt <= nxt_idx;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push != pop) cnt <= push ? cnt + 1'b1 : cnt - 1'b1;
    end
  end
endmodule

// File: tb/tb_shared_fifo_ctrl.sv
// tb_shared_fifo_ctrl: directed checks of arbitration, pointers, boundaries, enable and reset
module tb_shared_fifo_ctrl;
  logic       clock = 1'b0, reset, enable, pop_req;
  logic [3:0] req, gnt;
  logic       push, pop, full, empty;
  logic [2:0] wr_addr, rd_addr;
  logic [3:0] count;
  int checks = 0, errors = 0;

  shared_fifo_ctrl #(.NUM_REQ(4), .DEPTH(8), .ADDR_W(3)) dut (
    .clock(clock), .reset(reset), .enable(enable), .req(req), .pop_req(pop_req),
    .gnt(gnt), .push(push), .pop(pop), .wr_addr(wr_addr), .rd_addr(rd_addr),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set(input logic [3:0] q, input logic p);
    req = q;
    pop_req = p;
    #1;
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic run(input logic [3:0] q, input logic p, input int n);
    for (int i = 0; i < n; i++) begin
      set(q, p);
      tick();
    end
  endtask

  task automatic state(input string tag, input int c, input int w, input int r);
    chk({tag, "_count"}, count, c);
    chk({tag, "_wr"}, wr_addr, w);
    chk({tag, "_rd"}, rd_addr, r);
    chk({tag, "_full"}, full, c == 8);
    chk({tag, "_empty"}, empty, c == 0);
  endtask

  initial begin
    reset = 1'b0; enable = 1'b1; req = 4'b1111; pop_req = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      set(4'b1111, 1'b1);
      chk("rst_gnt", gnt, 0);
      chk("rst_push", push, 0);
      chk("rst_pop", pop, 0);
      tick();
    end
    state("rst", 0, 0, 0);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set(4'b0001, 1'b0);
      chk("fill_gnt", gnt, 4'b0001);
      chk("fill_wr", wr_addr, i);
      tick();
    end
    state("filled", 8, 0, 0);
    set(4'b0001, 1'b0);
    chk("full_gnt", gnt, 0);
    chk("full_push", push, 0);
    tick();
    run(4'b0000, 1'b1, 6);
    state("drain", 2, 0, 6);
    set(4'b1000, 1'b1);
    chk("pre_rr_gnt", gnt, 4'b1000);
    tick();
    for (int i = 0; i < 5; i++) begin
      logic [3:0] exp_g;
      exp_g = 4'b0001 << (i % 4);
      set(4'b1111, 1'b1);
      chk("rr_gnt", gnt, exp_g);
      chk("rr_pop", pop, 1);
      tick();
      chk("rr_count", count, 2);
    end
    for (int i = 0; i < 4; i++) begin
      set(4'b1010, 1'b1);
      chk("alt_gnt", gnt, i % 2 == 0 ? 4'b0010 : 4'b1000);
      tick();
    end
    state("after_rr", 2, 2, 0);
    run(4'b0001, 1'b0, 6);
    state("refill", 8, 0, 0);
    set(4'b0001, 1'b1);
    chk("bfull_push", push, 0);
    chk("bfull_pop", pop, 1);
    tick();
    state("bfull", 7, 0, 1);
    run(4'b0000, 1'b1, 7);
    state("bempty_pre", 0, 0, 0);
    set(4'b0001, 1'b1);
    chk("bempty_push", push, 1);
    chk("bempty_pop", pop, 0);
    tick();
    state("bempty", 1, 1, 0);
    run(4'b0001, 1'b0, 2);
    set(4'b0001, 1'b1);
    chk("bmid_push", push, 1);
    chk("bmid_pop", pop, 1);
    tick();
    state("bmid", 3, 4, 1);
    run(4'b0000, 1'b1, 3);
    for (int i = 0; i < 4; i++) begin
      run(4'b0001, 1'b0, 1);
      run(4'b0000, 1'b1, 1);
    end
    state("wrap_pre", 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      run(4'b0001, 1'b0, 1);
      chk("wrap_cnt1", count, 1);
      run(4'b0000, 1'b1, 1);
      chk("wrap_cnt0", count, 0);
    end
    state("wrap", 0, 2, 2);
    run(4'b0001, 1'b0, 1);
    state("en_pre", 1, 3, 2);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set(4'b0001, 1'b1);
      chk("en_gnt", gnt, 0);
      chk("en_push", push, 0);
      chk("en_pop", pop, 0);
      tick();
      state("en_hold", 1, 3, 2);
    end
    enable = 1'b1;
    run(4'b0000, 1'b1, 1);
    for (int i = 0; i < 5; i++) begin
      run(4'b0001, 1'b0, 1);
      run(4'b0000, 1'b1, 1);
    end
    state("mid_pre0", 0, 0, 0);
    run(4'b0100, 1'b0, 5);
    state("mid_pre", 5, 5, 0);
    reset = 1'b0;
    set(4'b1111, 1'b1);
    chk("mid_rst_gnt", gnt, 0);
    chk("mid_rst_pop", pop, 0);
    tick();
    reset = 1'b1;
    set(4'b1111, 1'b0);
    state("mid_rst", 0, 0, 0);
    chk("mid_first_gnt", gnt, 4'b0001);
    tick();
    chk("mid_after_count", count, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
